// File: rtl/fetch_dispatch.sv
// Instruction fetch/dispatch sequencer: owns the PC, fetches 16-bit words,
// retires NOP/JMP/HALT locally and hands ALU words to the downstream ALU FSM.
//
// state      | meaning
// S_FETCH    | mem_rd high at address pc; latch word when mem_ready
// S_DECODE   | one cycle: retire NOP/JMP, park in HALT, or launch the ALU
// S_EXEC_ALU | ALU FSM running; apply pc_inc pulses, wait for done or timeout
// S_HALT     | parked until reset; halted high, no memory reads

module fetch_dispatch #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [15:0]       mem_data_i,
  input  logic              mem_ready_i,
  output logic [15:0]       instruction_o,
  output logic              alu_start_o,
  input  logic              alu_done_i,
  input  logic              alu_pc_inc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o,
  output logic              fault_o
);

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_DECODE   = 2'd1,
    S_EXEC_ALU = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  localparam logic [1:0] CLS_NOP  = 2'b00;
  localparam logic [1:0] CLS_HALT = 2'b01;
  localparam logic [1:0] CLS_ALU  = 2'b10;
  localparam logic [7:0] WD_LAST  = 8'(TIMEOUT - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_plus_d;
  logic [15:0]       instr_q;
  logic              alu_start_q;
  logic              halted_q;
  logic              fault_q;
  logic [7:0]        wdog_q;

  // Modulo-2^ADDR_W increment; wrap from all-ones to zero is silent.
  assign pc_plus_d = pc_q + ADDR_W'(1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      instr_q     <= '0;
      alu_start_q <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
      wdog_q      <= '0;
    end else begin
      alu_start_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (mem_ready_i) begin
            instr_q <= mem_data_i;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (instr_q[15:14])
            CLS_NOP: begin
              pc_q    <= pc_plus_d;
              state_q <= S_FETCH;
            end
            CLS_HALT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            CLS_ALU: begin
              alu_start_q <= 1'b1;
              wdog_q      <= '0;
              state_q     <= S_EXEC_ALU;
            end
            default: begin
              pc_q    <= instr_q[ADDR_W-1:0];
              state_q <= S_FETCH;
            end
          endcase
        end
        S_EXEC_ALU: begin
          // done and pc_inc together: the increment lands before the next fetch.
          if (alu_pc_inc_i) begin
            pc_q <= pc_plus_d;
          end
          if (alu_done_i) begin
            state_q <= S_FETCH;
          end else if (wdog_q == WD_LAST) begin
            fault_q  <= 1'b1;
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        default: begin
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  // Read strobe decodes the state register; gated by reset so it reads low
  // while reset is held even though the reset state is S_FETCH.
  assign mem_rd_o      = rst_i && (state_q == S_FETCH);
  assign mem_addr_o    = pc_q;
  assign pc_o          = pc_q;
  assign instruction_o = instr_q;
  assign alu_start_o   = alu_start_q;
  assign halted_o      = halted_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_fetch_dispatch.sv
// Scoreboard bench for fetch_dispatch: directed programs in a zero/wait-state
// memory model, a stub ALU FSM, and a negedge monitor checking fetches/starts.

module tb_fetch_dispatch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  mem_addr_o;
  logic        mem_rd_o;
  logic [15:0] mem_data_i;
  logic        mem_ready_i;
  logic [15:0] instruction_o;
  logic        alu_start_o;
  logic        alu_done_i;
  logic        alu_pc_inc_i;
  logic [7:0]  pc_o;
  logic        halted_o;
  logic        fault_o;

  logic [15:0] mem [256];
  logic        stub_done, stub_inc, hold_alu;
  bit          stub_en;
  int          stub_delay;
  int          total = 0;
  int          bad = 0;
  int          start_cnt = 0;
  logic        start_prev;
  logic [7:0]  exp_fetch [$];
  logic [15:0] exp_start [$];

  always #5 clk_i = ~clk_i;

  assign mem_data_i   = mem[mem_addr_o];
  assign alu_done_i   = stub_done | hold_alu;
  assign alu_pc_inc_i = stub_inc | hold_alu;

  fetch_dispatch #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o),
    .mem_data_i(mem_data_i), .mem_ready_i(mem_ready_i),
    .instruction_o(instruction_o), .alu_start_o(alu_start_o),
    .alu_done_i(alu_done_i), .alu_pc_inc_i(alu_pc_inc_i),
    .pc_o(pc_o), .halted_o(halted_o), .fault_o(fault_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT fetches or starts the ALU.
  initial begin
    start_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i && mem_rd_o && mem_ready_i && exp_fetch.size() > 0)
        check("fetch_addr", 32'(mem_addr_o), 32'(exp_fetch.pop_front()));
      if (rst_i && alu_start_o) begin
        start_cnt++;
        check("start_single_cycle", 32'(start_prev), 0);
        if (exp_start.size() > 0)
          check("start_instr", 32'(instruction_o), 32'(exp_start.pop_front()));
        else
          check("start_unexpected", 32'(alu_start_o), 0);
      end
      start_prev = alu_start_o;
    end
  end

  // Stub ALU FSM: done+pcInc together stub_delay cycles after alu_start.
  initial begin
    stub_done = 1'b0;
    stub_inc  = 1'b0;
    forever begin
      @(negedge clk_i);
      if (stub_en && rst_i && alu_start_o) begin
        repeat (stub_delay) @(posedge clk_i);
        #1;
        stub_done = 1'b1;
        stub_inc  = 1'b1;
        @(posedge clk_i);
        #1;
        stub_done = 1'b0;
        stub_inc  = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stalled");
  end

  task automatic reset_dut();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("queues_drained", 32'(exp_fetch.size() + exp_start.size()), 0);
    @(negedge clk_i);
    check("rst_pc", 32'(pc_o), 0);
    check("rst_mem_rd", 32'(mem_rd_o), 0);
    check("rst_instr", 32'(instruction_o), 0);
    check("rst_alu_start", 32'(alu_start_o), 0);
    check("rst_halted", 32'(halted_o), 0);
    check("rst_fault", 32'(fault_o), 0);
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    exp_fetch.delete();
    exp_start.delete();
    stub_en     = 1'b0;
    stub_delay  = 3;
    hold_alu    = 1'b0;
    mem_ready_i = 1'b1;
  endtask

  task automatic release_dut();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (alu_start_o) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit   found;
    int   errs;
    logic [7:0] pc_tab [5];
    rst_i       = 1'b0;
    mem_ready_i = 1'b1;
    hold_alu    = 1'b0;
    stub_en     = 1'b0;
    stub_delay  = 3;

    // 1: all-NOP memory, zero wait: pc steps every 2 cycles, no alu_start
    reset_dut();
    for (int a = 0; a < 5; a++) exp_fetch.push_back(8'(a));
    release_dut();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      check("nop_pc", 32'(pc_o), 32'(k / 2));
      check("nop_mem_rd", 32'(mem_rd_o), 32'((k % 2) == 0));
    end
    check("nop_no_start", 32'(start_cnt), 0);

    // 2: ALU Add R1 R2 with stub done+pcInc 3 cycles after start
    reset_dut();
    mem[0]  = 16'h8042;
    stub_en = 1'b1;
    exp_fetch.push_back(8'h00);
    exp_fetch.push_back(8'h01);
    exp_start.push_back(16'h8042);
    release_dut();
    wait_start(found);
    check("alu_start_seen", 32'(found), 1);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk_i);
      check("alu_instr_stable", 32'(instruction_o), 32'h8042);
      check("alu_pc_held", 32'(pc_o), 0);
      if (j == 1) check("alu_start_low_e2", 32'(alu_start_o), 0);
    end
    @(negedge clk_i);
    check("alu_pc_after", 32'(pc_o), 1);
    check("alu_refetch_rd", 32'(mem_rd_o), 1);
    check("alu_refetch_addr", 32'(mem_addr_o), 1);

    // 3: JMP A5 then HALT: halted, no reads for 20 cycles
    reset_dut();
    mem[8'h00] = 16'hC0A5;
    mem[8'hA5] = 16'h4000;
    exp_fetch.push_back(8'h00);
    exp_fetch.push_back(8'hA5);
    release_dut();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i);
      found = halted_o;
    end
    check("halt_seen", 32'(found), 1);
    check("halt_pc", 32'(pc_o), 32'hA5);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (mem_rd_o !== 1'b0 || halted_o !== 1'b1) errs++;
    end
    check("halt_no_reads", 32'(errs), 0);

    // 4: JMP FF, NOP at FF wraps to 00; ALU inputs held high are ignored
    reset_dut();
    mem[8'h00] = 16'hC0FF;
    mem[8'hFF] = 16'h0000;
    hold_alu   = 1'b1;
    exp_fetch.push_back(8'h00);
    exp_fetch.push_back(8'hFF);
    exp_fetch.push_back(8'h00);
    pc_tab = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
    release_dut();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("wrap_pc", 32'(pc_o), 32'(pc_tab[k]));
    end
    check("wrap_no_fault", 32'(fault_o), 0);
    check("wrap_no_halt", 32'(halted_o), 0);

    // 5: ALU never completes: fault after 16 EXEC cycles, sticky
    reset_dut();
    mem[0] = 16'h8042;
    exp_fetch.push_back(8'h00);
    exp_start.push_back(16'h8042);
    release_dut();
    wait_start(found);
    check("to_start_seen", 32'(found), 1);
    repeat (15) @(negedge clk_i);
    check("to_fault_early", 32'(fault_o), 0);
    check("to_halt_early", 32'(halted_o), 0);
    @(negedge clk_i);
    check("to_fault", 32'(fault_o), 1);
    check("to_halted", 32'(halted_o), 1);
    repeat (10) @(negedge clk_i);
    check("to_fault_sticky", 32'(fault_o), 1);
    check("to_no_reads", 32'(mem_rd_o), 0);

    // 6: wait states hold the fetch, then async reset mid-EXEC_ALU
    reset_dut();
    mem[0]      = 16'h0000;
    mem[1]      = 16'h8042;
    mem_ready_i = 1'b0;
    release_dut();
    errs = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      if (mem_rd_o !== 1'b1 || instruction_o !== 16'h0000 || pc_o !== 8'h00) errs++;
    end
    check("ws_hold", 32'(errs), 0);
    exp_fetch.push_back(8'h00);
    exp_fetch.push_back(8'h01);
    exp_start.push_back(16'h8042);
    @(posedge clk_i);
    #1;
    mem_ready_i = 1'b1;
    wait_start(found);
    check("ws_start_seen", 32'(found), 1);
    repeat (2) @(negedge clk_i);
    check("ws_pc_exec", 32'(pc_o), 1);
    check("ws_instr_exec", 32'(instruction_o), 32'h8042);
    #1;
    rst_i = 1'b0;
    #1;
    check("arst_pc", 32'(pc_o), 0);
    check("arst_instr", 32'(instruction_o), 0);
    check("arst_mem_rd", 32'(mem_rd_o), 0);
    check("arst_start", 32'(alu_start_o), 0);
    check("arst_halted", 32'(halted_o), 0);
    check("arst_fault", 32'(fault_o), 0);
    @(posedge clk_i);
    #1;
    check("final_drained", 32'(exp_fetch.size() + exp_start.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
